// File: rtl/melody_sequencer.sv
// Piezo melody sequencer: plays a 16-entry note list through a single-voice square-wave divider.
// Optional SEQ_OCTAVE_EN adds OCT_UP, sampled per entry, which raises the pitch one octave.
module melody_sequencer #(
  parameter int unsigned CLK_HZ    = 12000000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic        CLK_IN,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic        LOOP,
  input  logic        WR_EN,
  input  logic [3:0]  WR_ADDR,
  input  logic [12:0] WR_DATA,
`ifdef SEQ_OCTAVE_EN
  input  logic        OCT_UP,
`endif
  output logic        BZ,
  output logic        BUSY,
  output logic [2:0]  NOTE_IDX,
  output logic [3:0]  PTR,
  output logic        DONE
);

  localparam int unsigned TICK_CYC  = (CLK_HZ / TICK_HZ > 0) ? CLK_HZ / TICK_HZ : 1;
  localparam logic [31:0] TICK_LAST = 32'(TICK_CYC - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP_TICKS - 1);

  function automatic int unsigned hp_of_freq(input int unsigned f);
    int unsigned hp;
    hp = CLK_HZ / (2 * f);
    return (hp == 0) ? 1 : hp;
  endfunction

  localparam int unsigned HP_TAB [8] = '{hp_of_freq(523), hp_of_freq(587), hp_of_freq(659),
                                         hp_of_freq(698), hp_of_freq(783), hp_of_freq(880),
                                         hp_of_freq(987), hp_of_freq(1046)};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t      state_q, state_d;
  logic [12:0] mem_q [16];
  logic [3:0]  ptr_q, ptr_d;
  logic [31:0] cyc_q, cyc_d;
  logic [7:0]  tick_q, tick_d;
  logic [31:0] phase_q, phase_d;
  logic        bz_q, bz_d;
  logic        done_q, done_d;
  logic [2:0]  note_q, note_d;
  logic        rest_q, rest_d;
  logic [7:0]  dur_q, dur_d;
  logic [31:0] hp_base, hp_cur;

  logic [12:0] entry;
  logic        e_end, e_rest;
  logic [2:0]  e_note;
  logic [7:0]  e_dur;
  logic        tick_wrap, play_done, gap_done, to_adv, to_eol, eol_wrap;

  always_ff @(posedge CLK_IN) begin
    if (WR_EN) mem_q[WR_ADDR] <= WR_DATA;
  end

  assign entry  = mem_q[ptr_q];
  assign e_end  = entry[12];
  assign e_rest = entry[11];
  assign e_note = entry[10:8];
  assign e_dur  = entry[7:0];

  assign hp_base = HP_TAB[note_q];
`ifdef SEQ_OCTAVE_EN
  logic oct_q, oct_d;
  assign hp_cur = (oct_q && hp_base > 32'd1) ? (hp_base >> 1) : hp_base;
`else
  assign hp_cur = hp_base;
`endif

  assign tick_wrap = (cyc_q == TICK_LAST);
  assign play_done = (state_q == S_PLAY) && tick_wrap && (tick_q == dur_q - 8'd1);
  assign gap_done  = (state_q == S_GAP) && tick_wrap && (tick_q == GAP_LAST);
  assign to_adv    = ((state_q == S_LOAD) && !e_end && (e_dur == 8'd0))
                   || (play_done && (GAP_TICKS == 0)) || gap_done;
  // Entry 15 is followed by an implicit END; an END at entry 0 never loops so an empty list halts.
  assign to_eol    = ((state_q == S_LOAD) && e_end) || (to_adv && (ptr_q == 4'd15));
  assign eol_wrap  = LOOP && !((state_q == S_LOAD) && e_end && (ptr_q == 4'd0));

  always_ff @(posedge CLK_IN) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (START && !STOP) state_d = S_LOAD;
      S_LOAD:  if (!e_end && (e_dur != 8'd0)) state_d = S_PLAY;
      S_PLAY:  if (play_done) state_d = S_GAP;
      default: ;
    endcase
    if (to_eol)      state_d = eol_wrap ? S_LOAD : S_IDLE;
    else if (to_adv) state_d = S_LOAD;
    if (STOP && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    ptr_d   = ptr_q;
    cyc_d   = cyc_q;
    tick_d  = tick_q;
    phase_d = phase_q;
    bz_d    = bz_q;
    done_d  = 1'b0;
    note_d  = note_q;
    rest_d  = rest_q;
    dur_d   = dur_q;
`ifdef SEQ_OCTAVE_EN
    oct_d   = oct_q;
`endif
    BUSY     = (state_q != S_IDLE);
    NOTE_IDX = (state_q == S_PLAY) ? note_q : 3'd0;
    case (state_q)
      S_IDLE: begin
        bz_d = 1'b0;
        if (START && !STOP) ptr_d = 4'd0;
      end
      S_LOAD: begin
        cyc_d   = '0;
        tick_d  = '0;
        phase_d = '0;
        bz_d    = 1'b0;
        if (!e_end && (e_dur != 8'd0)) begin
          note_d = e_note;
          rest_d = e_rest;
          dur_d  = e_dur;
`ifdef SEQ_OCTAVE_EN
          oct_d  = OCT_UP;
`endif
        end
      end
      default: begin
        cyc_d  = tick_wrap ? '0 : cyc_q + 32'd1;
        tick_d = tick_wrap ? tick_q + 8'd1 : tick_q;
        if (state_q == S_GAP) begin
          bz_d = 1'b0;
        end else if (!rest_q) begin
          if (phase_q == hp_cur - 32'd1) begin
            phase_d = '0;
            bz_d    = ~bz_q;
          end else begin
            phase_d = phase_q + 32'd1;
          end
        end
        if (play_done) begin
          cyc_d  = '0;
          tick_d = '0;
          bz_d   = 1'b0;
        end
      end
    endcase
    if (to_eol) begin
      ptr_d  = 4'd0;
      done_d = !eol_wrap;
    end else if (to_adv) begin
      ptr_d = ptr_q + 4'd1;
    end
    if (STOP && (state_q != S_IDLE)) begin
      ptr_d  = 4'd0;
      bz_d   = 1'b0;
      done_d = 1'b0;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      ptr_q   <= '0;
      cyc_q   <= '0;
      tick_q  <= '0;
      phase_q <= '0;
      bz_q    <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= '0;
      rest_q  <= 1'b0;
      dur_q   <= '0;
`ifdef SEQ_OCTAVE_EN
      oct_q   <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      cyc_q   <= cyc_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      bz_q    <= bz_d;
      done_q  <= done_d;
      note_q  <= note_d;
      rest_q  <= rest_d;
      dur_q   <= dur_d;
`ifdef SEQ_OCTAVE_EN
      oct_q   <= oct_d;
`endif
    end
  end

  assign BZ   = bz_q;
  assign PTR  = ptr_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: an entry-level reference model predicts the per-cycle outputs.
module tb_melody_sequencer;
  localparam int TICK = 12;
  localparam int GAP  = 2;
  localparam int FREQ [8] = '{523, 587, 659, 698, 783, 880, 987, 1046};

  logic clk = 1'b0;
  logic RST, START, STOP, LOOP, WR_EN;
  logic [3:0] WR_ADDR;
  logic [12:0] WR_DATA;
  logic BZ, BUSY, DONE;
  logic [2:0] NOTE_IDX;
  logic [3:0] PTR;

  always #5 clk = ~clk;

  melody_sequencer #(.CLK_HZ(12000), .TICK_HZ(1000), .GAP_TICKS(2)) dut (
    .CLK_IN(clk), .RST(RST), .START(START), .STOP(STOP), .LOOP(LOOP),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
`ifdef SEQ_OCTAVE_EN
    .OCT_UP(1'b0),
`endif
    .BZ(BZ), .BUSY(BUSY), .NOTE_IDX(NOTE_IDX), .PTR(PTR), .DONE(DONE)
  );

  typedef struct {
    int       cyc;
    bit       bz;
    bit       busy;
    bit [2:0] note;
    bit [3:0] ptr;
    bit       done;
    bit       chkp;
  } exp_t;

  exp_t sb[$];
  exp_t model_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_now = 0;
  logic [12:0] mem_m [16];
  int m_stop, m_drop, m_wr_c;
  logic [3:0] m_wr_a;
  logic [12:0] m_wr_d;
  bit m_fin;

  initial forever begin
    @(posedge clk);
    cyc_now++;
  end

  // Monitor: compares every cycle for which an expectation has been queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc_now) begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != cyc_now) begin
          errors++;
          $display("FAIL late_sample cycle=%0d expected_for=%0d", cyc_now, e.cyc);
        end else if (BZ !== e.bz || BUSY !== e.busy || NOTE_IDX !== e.note || DONE !== e.done ||
                     (e.chkp && PTR !== e.ptr)) begin
          errors++;
          $display("FAIL outputs cycle=%0d got bz=%b busy=%b note=%0d ptr=%0d done=%b want bz=%b busy=%b note=%0d ptr=%0d(chk=%0d) done=%b",
                   cyc_now, BZ, BUSY, NOTE_IDX, PTR, DONE, e.bz, e.busy, e.note, e.ptr, e.chkp, e.done);
        end
      end
    end
  end

  function automatic bit loop_at(input int c);
    return c < m_drop;
  endfunction

  function automatic logic [12:0] mem_at(input int a, input int c);
    if (m_wr_c > 0 && c > m_wr_c && 4'(a) == m_wr_a) return m_wr_d;
    return mem_m[a];
  endfunction

  task automatic mpush(input bit busy, input int ptr, input bit bz, input int note, input bit done,
                       input bit chkp);
    exp_t e;
    int c;
    if (m_fin) return;
    c = model_q.size() + 1;
    e.cyc = c; e.bz = bz; e.busy = busy; e.note = 3'(note); e.ptr = 4'(ptr); e.done = done; e.chkp = chkp;
    if (m_stop > 0 && c == m_stop + 1) begin
      e.bz = 0; e.busy = 0; e.note = 0; e.ptr = 0; e.done = 0; e.chkp = 1;
      m_fin = 1;
    end else if (!busy) begin
      m_fin = 1;
    end
    model_q.push_back(e);
  endtask

  // Walks the note list entry by entry: LOAD, dur*TICK play cycles, GAP*TICK silent cycles.
  task automatic build();
    int p, n, hp, cl;
    logic [12:0] e;
    bit eol;
    model_q.delete();
    m_fin = 0;
    p = 0;
    while (!m_fin && model_q.size() < 20000) begin
      mpush(1, p, 0, 0, 0, 1);
      if (m_fin) break;
      cl = model_q.size();
      e = mem_at(p, cl);
      eol = 0;
      if (e[12]) begin
        eol = 1;
      end else begin
        if (e[7:0] != 8'd0) begin
          n = int'(e[7:0]) * TICK;
          hp = 12000 / (2 * FREQ[e[10:8]]);
          if (hp < 1) hp = 1;
          for (int k = 0; k < n; k++)
            mpush(1, p, e[11] ? 1'b0 : (((k / hp) % 2) != 0), int'(e[10:8]), 0, 1);
          for (int k = 0; k < GAP * TICK; k++) mpush(1, p, 0, 0, 0, 1);
          if (m_fin) break;
        end
        if (p == 15) eol = 1;
        else p++;
      end
      if (eol) begin
        if (loop_at(model_q.size()) && !(e[12] && p == 0)) p = 0;
        else mpush(0, 0, 0, 0, 1, 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      WR_EN = 1; WR_ADDR = 4'(i); WR_DATA = mem_m[i];
      tick();
    end
    WR_EN = 0;
  endtask

  task automatic push_idle(input int base, input int from, input int to, input bit chkp);
    exp_t e;
    for (int k = from; k <= to; k++) begin
      e.cyc = base + k; e.bz = 0; e.busy = 0; e.note = 0; e.ptr = 0; e.done = 0; e.chkp = chkp;
      sb.push_back(e);
    end
  endtask

  task automatic run_seq(input string name, input int stop_s, input bit use_rst, input int drop_c,
                         input int xstart, input int wr_c, input logic [3:0] wr_a, input logic [12:0] wr_d);
    int len, base;
    exp_t e;
    m_stop = stop_s; m_drop = drop_c; m_wr_c = wr_c; m_wr_a = wr_a; m_wr_d = wr_d;
    build();
    len = model_q.size();
    base = cyc_now;
    foreach (model_q[i]) begin
      e = model_q[i];
      e.cyc = e.cyc + base;
      sb.push_back(e);
    end
    push_idle(base, len + 1, len + 3, 0);
    for (int r = 0; r <= len + 3; r++) begin
      START = (r == 0) || (xstart > 0 && r == xstart);
      STOP  = (stop_s > 0) && !use_rst && (r == stop_s);
      RST   = (stop_s > 0) && use_rst && (r == stop_s);
      LOOP  = loop_at(r);
      WR_EN = (wr_c > 0) && (r == wr_c);
      WR_ADDR = wr_a; WR_DATA = wr_d;
      tick();
    end
    START = 0; STOP = 0; RST = 0; LOOP = 0; WR_EN = 0;
    if (wr_c > 0 && wr_c <= len + 3) mem_m[wr_a] = wr_d;
    $display("txn %s: cycles=%0d stop=%0d rst=%0d loop_until=%0d extra_start=%0d write_at=%0d",
             name, len, stop_s, use_rst, drop_c, xstart, wr_c);
  endtask

  function automatic logic [12:0] gen_entry();
    logic [7:0] dur;
    if ($urandom_range(0, 11) == 0) return 13'h1000 | 13'($urandom_range(0, 4095));
    dur = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 2));
    return {1'b0, $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), dur};
  endfunction

  initial begin
    int base, len, stop_s, xs, drop, wc;
    logic [3:0] wa;
    logic [12:0] wd;
    RST = 1; START = 0; STOP = 0; LOOP = 0; WR_EN = 0; WR_ADDR = 0; WR_DATA = 0;
    repeat (3) tick();
    RST = 0;
    push_idle(cyc_now, 0, 3, 1);
    repeat (4) tick();
    $display("txn reset: idle outputs checked");

    foreach (mem_m[i]) mem_m[i] = 13'h1000;
    mem_m[0] = 13'h0003;
    load_prog();
    run_seq("single_note", 0, 0, 0, 0, 0, 4'd0, 13'd0);

    mem_m[0] = 13'h0F02;
    load_prog();
    run_seq("rest", 0, 0, 0, 0, 0, 4'd0, 13'd0);

    mem_m[0] = 13'h0701;
    load_prog();
    run_seq("loop_then_drop", 0, 0, 150, 0, 0, 4'd0, 13'd0);

    mem_m[0] = 13'h0003;
    load_prog();
    run_seq("stop_mid_note", 12, 0, 0, 0, 0, 4'd0, 13'd0);
    run_seq("restart_after_stop", 0, 0, 0, 20, 0, 4'd0, 13'd0);

    base = cyc_now;
    push_idle(base, 1, 5, 1);
    START = 1; STOP = 1;
    tick();
    START = 0; STOP = 0;
    repeat (6) tick();
    $display("txn start_and_stop_same_cycle: stays idle");

    run_seq("reset_mid_play", 12, 1, 0, 0, 0, 4'd0, 13'd0);
    run_seq("replay_after_reset", 0, 0, 0, 0, 0, 4'd0, 13'd0);

    for (int i = 0; i < 16; i++) mem_m[i] = {2'b00, 3'(i % 8), 8'd1};
    mem_m[5] = 13'h0500;
    load_prog();
    run_seq("full_list_skip", 0, 0, 0, 0, 0, 4'd0, 13'd0);

    for (int t = 0; t < 25; t++) begin
      foreach (mem_m[i]) mem_m[i] = gen_entry();
      load_prog();
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(50, 300)) : 0;
      wc = 0; wa = 4'($urandom_range(0, 15)); wd = gen_entry();
      m_stop = 0; m_drop = drop; m_wr_c = 0;
      build();
      len = model_q.size();
      if ($urandom_range(0, 1) == 0) wc = int'($urandom_range(1, len));
      m_wr_c = wc; m_wr_a = wa; m_wr_d = wd;
      build();
      len = model_q.size();
      stop_s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : 0;
      xs = int'($urandom_range(1, (stop_s > 0) ? stop_s : len - 1));
      run_seq("random", stop_s, $urandom_range(0, 1) == 1, drop, xs, wc, wa, wd);
    end

    repeat (3) tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain pending=%0d want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
